// File: rtl/pong_ball_ctrl.sv
// Pong ball-motion engine: serve sequencing, wall/paddle reflection, miss
// detection and score/hit pulses, advanced once per 100 Hz divider tick.
// Optional build macro: BALL_SPEEDUP_EN (every 4th paddle hit raises the step).
module pong_ball_ctrl #(
  parameter int unsigned FIELD_W     = 160,
  parameter int unsigned FIELD_H     = 120,
  parameter int unsigned BALL_SIZE   = 4,
  parameter int unsigned PADDLE_W    = 4,
  parameter int unsigned PADDLE_H    = 24,
  parameter int unsigned PADDLE_L_X  = 4,
  parameter int unsigned PADDLE_R_X  = 152,
  parameter int unsigned STEP        = 1,
  parameter int unsigned SERVE_TICKS = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_100Hz,
  input  logic       start,
  input  logic [7:0] paddle_l_y,
  input  logic [7:0] paddle_r_y,
  output logic [7:0] ball_x,
  output logic [7:0] ball_y,
  output logic       in_play,
  output logic       score_l,
  output logic       score_r,
  output logic       hit
);

  localparam int unsigned CTR_W = $clog2(SERVE_TICKS + 1);

  localparam logic [7:0] CX     = 8'((FIELD_W - BALL_SIZE) / 2);
  localparam logic [7:0] CY     = 8'((FIELD_H - BALL_SIZE) / 2);
  localparam logic [7:0] Y_MAX  = 8'(FIELD_H - BALL_SIZE);
  localparam logic [7:0] L_FACE = 8'(PADDLE_L_X + PADDLE_W);
  localparam logic [7:0] R_FACE = 8'(PADDLE_R_X - BALL_SIZE);
  localparam logic [8:0] BS9    = 9'(BALL_SIZE);
  localparam logic [8:0] PH9    = 9'(PADDLE_H);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_SCORE = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [7:0]       x_nxt, y_nxt;
  logic             dx, dx_nxt;   // 1 = moving right
  logic             dy, dy_nxt;   // 1 = moving down
  logic [CTR_W-1:0] cnt, cnt_nxt;
  logic             prev;
  logic             tick;
  logic             score_l_nxt, score_r_nxt, hit_nxt;
  logic [7:0]       step;
  logic [8:0]       y9;
  logic             over_l, over_r;

  assign tick = clk_100Hz & ~prev;

  // Paddle overlap in 9 bits so bottom-of-field sums never wrap
  always_comb begin
    y9     = {1'b0, ball_y};
    over_l = ((y9 + BS9) > {1'b0, paddle_l_y}) && (y9 < ({1'b0, paddle_l_y} + PH9));
    over_r = ((y9 + BS9) > {1'b0, paddle_r_y}) && (y9 < ({1'b0, paddle_r_y} + PH9));
  end

`ifdef BALL_SPEEDUP_EN
  localparam logic [7:0] MAX_STEP = 8'(4 * STEP);

  logic [1:0] hit_cnt;

  // Speed-up: every 4th paddle hit adds STEP, saturating; cleared on score
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt <= 2'd0;
      step    <= 8'(STEP);
    end else if (state == ST_SCORE) begin
      hit_cnt <= 2'd0;
      step    <= 8'(STEP);
    end else if (hit_nxt) begin
      hit_cnt <= hit_cnt + 2'd1;
      if (hit_cnt == 2'd3 && step < MAX_STEP) begin
        step <= step + 8'(STEP);
      end
    end
  end
`else
  assign step = 8'(STEP);
`endif

  // Next-state, motion and pulse decode
  always_comb begin
    state_nxt   = state;
    x_nxt       = ball_x;
    y_nxt       = ball_y;
    dx_nxt      = dx;
    dy_nxt      = dy;
    cnt_nxt     = cnt;
    score_l_nxt = 1'b0;
    score_r_nxt = 1'b0;
    hit_nxt     = 1'b0;

    case (state)
      ST_IDLE: begin
        x_nxt = CX;
        y_nxt = CY;
        if (start) begin
          state_nxt = ST_SERVE;
          cnt_nxt   = '0;
        end
      end

      ST_SERVE: begin
        if (tick) begin
          cnt_nxt = cnt + CTR_W'(1);
          if (cnt_nxt == CTR_W'(SERVE_TICKS)) begin
            state_nxt = ST_PLAY;
          end
        end
      end

      ST_PLAY: begin
        if (tick) begin
          // vertical axis: reflect off top and bottom walls
          if (dy) begin
            if (ball_y >= Y_MAX - step) begin
              y_nxt  = Y_MAX;
              dy_nxt = 1'b0;
            end else begin
              y_nxt = ball_y + step;
            end
          end else begin
            if (ball_y <= step) begin
              y_nxt  = 8'd0;
              dy_nxt = 1'b1;
            end else begin
              y_nxt = ball_y - step;
            end
          end

          // horizontal axis: paddle contact or miss near either face
          if (dx) begin
            if (ball_x >= R_FACE - step) begin
              if (over_r) begin
                x_nxt   = R_FACE;
                dx_nxt  = 1'b0;
                hit_nxt = 1'b1;
              end else begin
                state_nxt = ST_SCORE;
              end
            end else begin
              x_nxt = ball_x + step;
            end
          end else begin
            if (ball_x <= L_FACE + step) begin
              if (over_l) begin
                x_nxt   = L_FACE;
                dx_nxt  = 1'b1;
                hit_nxt = 1'b1;
              end else begin
                state_nxt = ST_SCORE;
              end
            end else begin
              x_nxt = ball_x - step;
            end
          end
        end
      end

      ST_SCORE: begin
        // dx still holds the direction of the miss: a rightward miss scores left
        score_l_nxt = dx;
        score_r_nxt = ~dx;
        dx_nxt      = ~dx;
        x_nxt       = CX;
        y_nxt       = CY;
        cnt_nxt     = '0;
        state_nxt   = ST_SERVE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      ball_x  <= CX;
      ball_y  <= CY;
      dx      <= 1'b1;
      dy      <= 1'b1;
      cnt     <= '0;
      prev    <= 1'b0;
      in_play <= 1'b0;
      score_l <= 1'b0;
      score_r <= 1'b0;
      hit     <= 1'b0;
    end else begin
      state   <= state_nxt;
      ball_x  <= x_nxt;
      ball_y  <= y_nxt;
      dx      <= dx_nxt;
      dy      <= dy_nxt;
      cnt     <= cnt_nxt;
      prev    <= clk_100Hz;
      in_play <= (state_nxt == ST_PLAY);
      score_l <= score_l_nxt;
      score_r <= score_r_nxt;
      hit     <= hit_nxt;
    end
  end

endmodule
